// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// address, execute and writeback, and decodes the ALU operation and immediate type.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    JAL      = 4'd8,
    LUI      = 4'd9,
    ALUWB    = 4'd10,
    BRANCH   = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [1:0] alu_op_s;
  logic       branch_s;
  logic       pc_update_s;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Immediate type follows the opcode in every state.
  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_LOAD:  imm_src = 3'b000;
      OP_ITYPE: imm_src = 3'b000;
      OP_STORE: imm_src = 3'b001;
      OP_BR:    imm_src = 3'b010;
      OP_JAL:   imm_src = 3'b011;
      OP_LUI:   imm_src = 3'b100;
      default:  imm_src = 3'b000;
    endcase
  end

  // ALU decoder; only register-register ops with funct7b5 set select subtract.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op_s)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000: begin
            if (op[5] & funct7b5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Branch resolution: funct3[0] inverts the zero test so bne shares the beq path.
  assign pc_write = pc_update_s | (branch_s & (zero ^ funct3[0]));

  // Next-state and per-state control outputs.
  always_comb begin
    state_next_s = state_r;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op_s     = ALUOP_ADD;
    reg_write    = 1'b0;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    branch_s     = 1'b0;
    pc_update_s  = 1'b0;
    case (state_r)
      FETCH: begin
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = mem_ready;
        pc_update_s = mem_ready;
        if (mem_ready) begin
          state_next_s = DECODE;
        end else begin
          state_next_s = FETCH;
        end
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD:  state_next_s = MEMADR;
          OP_STORE: state_next_s = MEMADR;
          OP_RTYPE: state_next_s = EXECR;
          OP_ITYPE: state_next_s = EXECI;
          OP_JAL:   state_next_s = JAL;
          OP_BR:    state_next_s = BRANCH;
          OP_LUI:   state_next_s = LUI;
          default:  state_next_s = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op[5]) begin
          state_next_s = MEMWRITE;
        end else begin
          state_next_s = MEMREAD;
        end
      end
      MEMREAD: begin
        result_src = 2'b00;
        adr_src    = 1'b1;
        if (mem_ready) begin
          state_next_s = MEMWB;
        end else begin
          state_next_s = MEMREAD;
        end
      end
      MEMWB: begin
        result_src   = 2'b01;
        reg_write    = 1'b1;
        instr_done   = 1'b1;
        state_next_s = FETCH;
      end
      MEMWRITE: begin
        result_src = 2'b00;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        if (mem_ready) begin
          instr_done   = 1'b1;
          state_next_s = FETCH;
        end else begin
          instr_done   = 1'b0;
          state_next_s = MEMWRITE;
        end
      end
      EXECR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b00;
        alu_op_s     = ALUOP_FUNC;
        state_next_s = ALUWB;
      end
      EXECI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        alu_op_s     = ALUOP_FUNC;
        state_next_s = ALUWB;
      end
      JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        result_src   = 2'b00;
        pc_update_s  = 1'b1;
        state_next_s = ALUWB;
      end
      LUI: begin
        alu_src_a    = 2'b11;
        alu_src_b    = 2'b01;
        state_next_s = ALUWB;
      end
      ALUWB: begin
        result_src   = 2'b00;
        reg_write    = 1'b1;
        instr_done   = 1'b1;
        state_next_s = FETCH;
      end
      BRANCH: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b00;
        alu_op_s     = ALUOP_SUB;
        result_src   = 2'b00;
        branch_s     = 1'b1;
        instr_done   = 1'b1;
        state_next_s = FETCH;
      end
      ILLEGAL: begin
        illegal      = 1'b1;
        state_next_s = ILLEGAL;
      end
      default: begin
        // Unused encodings are trapped rather than silently resumed.
        illegal      = 1'b1;
        state_next_s = ILLEGAL;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// and compares the full control-output vector against hand-derived values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic       reg_write, instr_done, illegal;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] outs;
  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, alu_control, imm_src, reg_write, instr_done, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic pcw, adr, mw, irw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] ac, imm,
                                     input logic rw, dn, il);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, dn, il};
  endfunction

  function automatic logic [18:0] fetch_v(input logic [2:0] imm, input logic rdy);
    return mk(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] decode_v(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] aluwb_v(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b1, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [18:0] exp);
    #1;
    check(tag, {13'd0, outs}, {13'd0, exp});
  endtask

  task automatic set_ir(input logic [31:0] ir);
    op = ir[6:0];
    funct3 = ir[14:12];
    funct7b5 = ir[30];
  endtask

  // ALU-decode table: {op, funct3, funct7b5, expected alu_control}
  logic [6:0] t_op [6] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
  logic [2:0] t_f3 [6] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b000, 3'b111};
  logic       t_f7 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] t_ac [6] = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b000, 3'b010};

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    set_ir(32'h00412083);
    #2;
    expect_out("reset_fetch", fetch_v(3'b000, 1'b1));
    tick();
    reset = 1'b0;

    // lw x1,4(x2): five cycles
    expect_out("lw_fetch", fetch_v(3'b000, 1'b1));
    tick(); expect_out("lw_decode", decode_v(3'b000));
    tick(); expect_out("lw_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    tick(); expect_out("lw_memread", mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    tick(); expect_out("lw_memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
    tick(); expect_out("lw_next_fetch", fetch_v(3'b000, 1'b1));

    // reset in the middle of MEMREAD
    tick(); tick(); tick();
    expect_out("rst_pre_memread", mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    expect_out("rst_mid_memread", fetch_v(3'b000, 1'b1));
    tick();
    reset = 1'b0;
    expect_out("rst_after_fetch", fetch_v(3'b000, 1'b1));
    tick(); expect_out("rst_after_decode", decode_v(3'b000));

    // restart cleanly and run the ALU decode table through EXECR/EXECI
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i];
      expect_out($sformatf("alu%0d_fetch", i), fetch_v(3'b000, 1'b1));
      tick(); expect_out($sformatf("alu%0d_decode", i), decode_v(3'b000));
      tick();
      expect_out($sformatf("alu%0d_exec", i),
                 mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, t_op[i][5] ? 2'b00 : 2'b01,
                    t_ac[i], 3'b000, 1'b0, 1'b0, 1'b0));
      tick(); expect_out($sformatf("alu%0d_aluwb", i), aluwb_v(3'b000));
      tick();
    end

    // sub x3,x1,x2 and addi with funct7b5 set
    set_ir(32'h402081B3);
    tick(); tick();
    expect_out("sub_execr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0));
    tick(); tick();
    set_ir(32'h40010093);
    tick(); tick();
    expect_out("addi_execi", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    tick(); tick();

    // branch: three cycles, pc_write resolved from zero and funct3[0]
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
    expect_out("br_fetch", fetch_v(3'b010, 1'b1));
    tick(); expect_out("br_decode", decode_v(3'b010));
    tick();
    zero = 1'b1;
    expect_out("beq_taken", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1'b0, 1'b1, 1'b0));
    zero = 1'b0;
    expect_out("beq_not_taken", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1'b0, 1'b1, 1'b0));
    funct3 = 3'b001; zero = 1'b1;
    expect_out("bne_not_taken", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1'b0, 1'b1, 1'b0));
    zero = 1'b0;
    expect_out("bne_taken", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1'b0, 1'b1, 1'b0));
    tick();

    // fetch stall of three cycles, then store with a two-cycle write stall
    op = 7'b0100011; funct3 = 3'b010;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("fetch_wait%0d", i), fetch_v(3'b001, 1'b0));
      tick();
    end
    mem_ready = 1'b1;
    expect_out("fetch_ready", fetch_v(3'b001, 1'b1));
    tick(); expect_out("sw_decode", decode_v(3'b001));
    tick(); expect_out("sw_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0));
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_out($sformatf("sw_wait%0d", i), mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0));
      tick();
    end
    mem_ready = 1'b1;
    expect_out("sw_done", mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0));
    tick();

    // jal and lui
    op = 7'b1101111;
    expect_out("jal_fetch", fetch_v(3'b011, 1'b1));
    tick(); tick();
    expect_out("jal_exec", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0));
    tick(); expect_out("jal_aluwb", aluwb_v(3'b011));
    tick();
    op = 7'b0110111;
    tick(); tick();
    expect_out("lui_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0));
    tick(); expect_out("lui_aluwb", aluwb_v(3'b100));
    tick();

    // all-zero instruction traps until reset
    set_ir(32'h00000000);
    expect_out("ill_fetch", fetch_v(3'b000, 1'b1));
    tick(); expect_out("ill_decode", decode_v(3'b000));
    for (int i = 0; i < 12; i++) begin
      tick();
      mem_ready = i[0];
      zero = i[1];
      expect_out($sformatf("illegal%0d", i), mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1));
    end
    mem_ready = 1'b1;
    reset = 1'b1;
    expect_out("ill_reset", fetch_v(3'b000, 1'b1));
    tick();
    reset = 1'b0;
    tick(); expect_out("ill_reset_decode", decode_v(3'b000));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
